// File: rtl/mem_pkg.sv
// mem_pkg: shared reset level and controller state type
// for the banked memory controller and its response FIFOs.
package mem_pkg;

  localparam logic RESET_STATE = 1'b0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/bank_rsp_fifo.sv
// bank_rsp_fifo: per-bank read response FIFO with fall-through
// when empty, so a response can leave the cycle it arrives.
module bank_rsp_fifo
  import mem_pkg::*;
#(
  parameter int DATA_L = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_L-1:0] push_data,
  input  logic              pop_ready,
  output logic              out_valid,
  output logic [DATA_L-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_L-1:0] store_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              empty;
  logic              wr_en;
  logic              rd_en;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (cnt_q == '0);
  assign out_valid = !empty || push_valid;
  assign out_data  = empty ? push_data
                           : store_q[rd_ptr_q];

  // Push straight through an empty FIFO is never stored.
  assign wr_en = push_valid && !(empty && pop_ready);
  assign rd_en = pop_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_en ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? nxt(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) store_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: N independent single-port banks with credit-
// limited reads, fixed-latency pipeline and in-order responses.
module banked_mem_ctrl
  import mem_pkg::*;
#(
  parameter int                DATA_L         = 32,
  parameter int                ADDR_L         = 10,
  parameter int                N_BANKS        = 8,
  parameter int                RD_LATENCY     = 1,
  parameter int                RSP_DEPTH      = 4,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_L-1:0] INIT_VALUE     = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_BANKS-1:0]             req_valid,
  output logic [N_BANKS-1:0]             req_ready,
  input  logic [N_BANKS-1:0]             req_wr,
  input  logic [N_BANKS-1:0][ADDR_L-1:0] req_addr,
  input  logic [N_BANKS-1:0][DATA_L-1:0] req_wr_data,
  output logic [N_BANKS-1:0]             rsp_valid,
  input  logic [N_BANKS-1:0]             rsp_ready,
  output logic [N_BANKS-1:0][DATA_L-1:0] rsp_data,
  output logic                           init_busy
);

  localparam int WORDS = 2 ** ADDR_L;
  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam ctrl_state_e RST_ST =
    CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  ctrl_state_e       state_q, state_d;
  logic [ADDR_L-1:0] sweep_q, sweep_d;
  logic              run;

  assign run       = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      state_q <= RST_ST;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [DATA_L-1:0] mem_q [WORDS];
    logic [CW-1:0]     outst_q, outst_d;
    logic [RD_LATENCY-1:0]             pv_q, pv_d;
    logic [RD_LATENCY-1:0][DATA_L-1:0] pd_q, pd_d;
    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic              rsp_hs;
    logic [DATA_L-1:0] f_data;

    // Credit counts pipeline plus FIFO, so the FIFO cannot overflow.
    assign req_ready[b] = run && (outst_q < CW'(RSP_DEPTH));
    assign acc    = req_valid[b] && req_ready[b];
    assign rd_acc = acc && !req_wr[b];
    assign wr_acc = acc && req_wr[b];
    assign rsp_hs = rsp_valid[b] && rsp_ready[b];

    always_ff @(posedge clk) begin
      if (state_q == ST_INIT) mem_q[sweep_q] <= INIT_VALUE;
      else if (wr_acc) mem_q[req_addr[b]] <= req_wr_data[b];
    end

    always_comb begin
      pv_d    = pv_q;
      pd_d    = pd_q;
      pv_d[0] = rd_acc;
      pd_d[0] = mem_q[req_addr[b]];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_d[i] = pv_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
      outst_d = outst_q;
      unique case ({rd_acc, rsp_hs})
        2'b10:   outst_d = outst_q + 1'b1;
        2'b01:   outst_d = outst_q - 1'b1;
        default: outst_d = outst_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (rst == RESET_STATE) begin
        pv_q    <= '0;
        pd_q    <= '0;
        outst_q <= '0;
      end else begin
        pv_q    <= pv_d;
        pd_q    <= pd_d;
        outst_q <= outst_d;
      end
    end

    bank_rsp_fifo #(
      .DATA_L (DATA_L),
      .DEPTH  (RSP_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (pv_q[RD_LATENCY-1]),
      .push_data  (pd_q[RD_LATENCY-1]),
      .pop_ready  (rsp_ready[b]),
      .out_valid  (rsp_valid[b]),
      .out_data   (f_data)
    );

    assign rsp_data[b] = rsp_valid[b] ? f_data : 'x;
  end

endmodule

// File: doc/banked_mem_ctrl.md
BANKED_MEM_CTRL -- requirements
Module: banked_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_L, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_L, default 10, per-bank word address width; each bank holds 2**ADDR_L words.
REQ-003 SHALL have parameter N_BANKS, default 8, number of independent banks.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal range is 1 to 4.
REQ-005 SHALL have parameter RSP_DEPTH, default 4, per-bank response buffer depth; RSP_DEPTH >= RD_LATENCY.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1; 1 means clear all banks after reset.
REQ-007 SHALL have parameter INIT_VALUE, default 0, DATA_L-bit clear value.
REQ-008 SHALL have clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-009 SHALL have rst, input, 1 bit: asynchronous active-low reset.
REQ-010 SHALL have req_valid, input, N_BANKS bits: per-bank request valid.
REQ-011 SHALL have req_ready, output, N_BANKS bits: per-bank request accept.
REQ-012 SHALL have req_wr, input, N_BANKS bits: 1 = write, 0 = read.
REQ-013 SHALL have req_addr, input, N_BANKS x ADDR_L bits: independent address per bank.
REQ-014 SHALL have req_wr_data, input, N_BANKS x DATA_L bits: per-bank write data.
REQ-015 SHALL have rsp_valid, output, N_BANKS bits: per-bank read data valid.
REQ-016 SHALL have rsp_ready, input, N_BANKS bits: per-bank consumer accept.
REQ-017 SHALL have rsp_data, output, N_BANKS x DATA_L bits: per-bank read data.
REQ-018 SHALL have init_busy, output, 1 bit: high while the clear sweep runs.

Function
REQ-019 SHALL implement a two-state controller, INIT and RUN; after reset it enters INIT if CLEAR_ON_RESET=1, else RUN.
REQ-020 In INIT, a sweep counter SHALL write INIT_VALUE to address 0..2**ADDR_L-1 in all banks in parallel, one address per cycle.
REQ-021 SHALL leave INIT for RUN in the cycle after address 2**ADDR_L-1 is written; the sweep takes exactly 2**ADDR_L cycles.
REQ-022 SHALL drive init_busy = (state==INIT) and force req_ready to all-zero during INIT.
REQ-023 A request SHALL be accepted in a cycle when req_valid[b] and req_ready[b] are both 1; banks are fully independent.
REQ-024 SHALL compute req_ready[b] = (state==RUN) && (outstanding[b] < RSP_DEPTH), independent of req_valid and req_wr (no combinational path from those inputs).
REQ-025 An accepted write SHALL update the word on that clock edge; a read to the same address in the next cycle SHALL return the new data.
REQ-026 Each accepted read SHALL increment outstanding[b]; each rsp handshake SHALL decrement it; both in one cycle leave it unchanged; the counter is $clog2(RSP_DEPTH+1) bits wide.
REQ-027 For a read accepted at cycle t, rsp_valid[b] SHALL assert no earlier than cycle t+RD_LATENCY, and exactly at t+RD_LATENCY if the buffer was empty and rsp_ready held high.
REQ-028 Read data SHALL pass through a RD_LATENCY-deep valid-tagged pipeline into a per-bank RSP_DEPTH-entry FIFO; the pipeline never stalls, which the credit rule in REQ-024 guarantees.
REQ-029 Responses SHALL return in request order per bank; rsp_data[b] is 'x when rsp_valid[b] is 0.
REQ-030 rsp_valid[b] and rsp_data[b] SHALL hold stable while rsp_valid[b] && !rsp_ready[b].
REQ-031 With the FIFO full and rsp_ready low, req_ready[b] SHALL be 0; the FIFO SHALL never overflow or underflow.
REQ-032 FIFO pointers SHALL wrap modulo RSP_DEPTH, and a simultaneous push and pop on a full or empty FIFO SHALL be handled correctly.

Reset
REQ-033 On rst low, asynchronously: state=INIT (or RUN if CLEAR_ON_RESET=0), sweep counter=0, outstanding=0, FIFOs empty, pipeline valids=0.
REQ-034 During and after reset, until the first handshake: req_ready=0 (while in INIT), rsp_valid=0, init_busy = CLEAR_ON_RESET.
REQ-035 A reset mid-operation SHALL discard all in-flight reads; memory contents SHALL be cleared only by the following INIT sweep.

Structure
REQ-036 A shared package mem_pkg SHALL hold RESET_STATE (1'b0) and the controller state enum type.
REQ-037 SHALL contain one sub-module, bank_rsp_fifo (DATA_L x RSP_DEPTH synchronous FIFO), instantiated once per bank; the storage array, read pipeline and credit counter stay in the top module.

Verification
REQ-038 Clear: reset with ADDR_L=4 -> init_busy high for exactly 16 cycles, then reading addresses 0..15 in every bank returns INIT_VALUE.
REQ-039 Write-then-read: bank 3 writes 0xDEADBEEF to address 5 at cycle t, reads it at t+1 -> rsp_data[3]=0xDEADBEEF at t+1+RD_LATENCY.
REQ-040 Backpressure: RSP_DEPTH=4, rsp_ready=0, bank 0 issues 6 reads -> exactly 4 accepted, req_ready[0]=0; then rsp_ready=1 -> 4 in-order responses.
REQ-041 Independent banks: all 8 banks read distinct addresses in one cycle with RD_LATENCY=3 -> all rsp_valid bits high together 3 cycles later, with correct per-bank data.
REQ-042 Reset mid-run: assert rst with 2 reads outstanding -> rsp_valid=0 immediately, outstanding=0, INIT sweep restarts.
